// File: rtl/ecc_pkg.sv
// Shared SECDED codeword layout: Hamming(7,4) at bits [6:0] plus overall even parity at bit 7.
// Used by both the codeword encoder and the receive-side decoder.
package ecc_pkg;

  localparam int CODE_W   = 8;
  localparam int SYN_W    = 3;
  localparam int DATA_W   = 4;

  localparam int P1_BIT   = 0;
  localparam int P2_BIT   = 1;
  localparam int D0_BIT   = 2;
  localparam int P4_BIT   = 3;
  localparam int D1_BIT   = 4;
  localparam int D2_BIT   = 5;
  localparam int D3_BIT   = 6;
  localparam int PALL_BIT = 7;

  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
    return {code[D3_BIT], code[D2_BIT], code[D1_BIT], code[D0_BIT]};
  endfunction

endpackage

// File: rtl/secded_decoder_if.sv
// Word-level valid/ready bus between the noisy channel, the SECDED decoder and its consumer.
// The decoder attaches as slave; the source/sink side attaches as master.
interface secded_decoder_if;
  import ecc_pkg::*;

  logic              i_valid;
  logic              o_ready;
  logic [CODE_W-1:0] i_code;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic              o_err_single;
  logic              o_err_double;
  logic [SYN_W-1:0]  o_syndrome;

  modport slave (
    input  i_valid, i_code, i_ready,
    output o_ready, o_valid, o_data, o_err_single, o_err_double, o_syndrome
  );

  modport master (
    output i_valid, i_code, i_ready,
    input  o_ready, o_valid, o_data, o_err_single, o_err_double, o_syndrome
  );
endinterface

// File: rtl/secded_decoder_syndrome.sv
// Combinational syndrome {s4,s2,s1} and overall parity of a received SECDED codeword.
// No state, zero latency.
module secded_syndrome
  import ecc_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [SYN_W-1:0]  syn_o,
  output logic              par_o
);

  logic s1, s2, s4;

  assign s1    = code_i[P1_BIT] ^ code_i[D0_BIT] ^ code_i[D1_BIT] ^ code_i[D3_BIT];
  assign s2    = code_i[P2_BIT] ^ code_i[D0_BIT] ^ code_i[D2_BIT] ^ code_i[D3_BIT];
  assign s4    = code_i[P4_BIT] ^ code_i[D1_BIT] ^ code_i[D2_BIT] ^ code_i[D3_BIT];
  assign syn_o = {s4, s2, s1};
  assign par_o = ^code_i;

endmodule

// File: rtl/secded_decoder.sv
// SECDED receive decoder: 2-stage valid/ready pipeline (syndrome, then correct/classify), 2-cycle latency.
// A stage advances when the next one is empty or draining; saturating single/double error counters.
module secded_decoder
  import ecc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  secded_decoder_if.slave  bus,
  input  logic             i_clr_cnt,
  output logic [CNT_W-1:0] o_cnt_single,
  output logic [CNT_W-1:0] o_cnt_double
);

  logic              s1_valid_q, s1_valid_d;
  logic [CODE_W-1:0] s1_code_q, s1_code_d;
  logic [SYN_W-1:0]  s1_syn_q, s1_syn_d;
  logic              s1_par_q, s1_par_d;

  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_data_q, s2_data_d;
  logic              s2_single_q, s2_single_d;
  logic              s2_double_q, s2_double_d;
  logic [SYN_W-1:0]  s2_syn_q, s2_syn_d;

  logic [CNT_W-1:0]  cnt_single_q, cnt_single_d;
  logic [CNT_W-1:0]  cnt_double_q, cnt_double_d;

  logic [SYN_W-1:0]  syn_w;
  logic              par_w;
  logic              s2_adv, s1_adv, out_fire;
  logic [CODE_W-1:0] corr_code;

  secded_syndrome u_syndrome (
    .code_i (bus.i_code),
    .syn_o  (syn_w),
    .par_o  (par_w)
  );

  assign s2_adv   = ~s2_valid_q | bus.i_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign out_fire = s2_valid_q & bus.i_ready;

  // A nonzero syndrome with odd parity points at the flipped bit; even parity means two flips.
  always_comb begin
    corr_code = s1_code_q;
    if (s1_par_q && (s1_syn_q != '0)) begin
      corr_code = s1_code_q ^ (CODE_W'(1) << (s1_syn_q - SYN_W'(1)));
    end
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_code_d    = s1_code_q;
    s1_syn_d     = s1_syn_q;
    s1_par_d     = s1_par_q;
    s2_valid_d   = s2_valid_q;
    s2_data_d    = s2_data_q;
    s2_single_d  = s2_single_q;
    s2_double_d  = s2_double_q;
    s2_syn_d     = s2_syn_q;
    cnt_single_d = cnt_single_q;
    cnt_double_d = cnt_double_q;

    if (s1_adv) begin
      s1_valid_d = bus.i_valid;
      if (bus.i_valid) begin
        s1_code_d = bus.i_code;
        s1_syn_d  = syn_w;
        s1_par_d  = par_w;
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d   = extract_data(corr_code);
        s2_single_d = s1_par_q;
        s2_double_d = ~s1_par_q & (s1_syn_q != '0);
        s2_syn_d    = s1_syn_q;
      end
    end

    if (i_clr_cnt) begin
      cnt_single_d = '0;
      cnt_double_d = '0;
    end else if (out_fire) begin
      if (s2_single_q && (cnt_single_q != '1)) cnt_single_d = cnt_single_q + CNT_W'(1);
      if (s2_double_q && (cnt_double_q != '1)) cnt_double_d = cnt_double_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_code_q    <= '0;
      s1_syn_q     <= '0;
      s1_par_q     <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_data_q    <= '0;
      s2_single_q  <= 1'b0;
      s2_double_q  <= 1'b0;
      s2_syn_q     <= '0;
      cnt_single_q <= '0;
      cnt_double_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_code_q    <= s1_code_d;
      s1_syn_q     <= s1_syn_d;
      s1_par_q     <= s1_par_d;
      s2_valid_q   <= s2_valid_d;
      s2_data_q    <= s2_data_d;
      s2_single_q  <= s2_single_d;
      s2_double_q  <= s2_double_d;
      s2_syn_q     <= s2_syn_d;
      cnt_single_q <= cnt_single_d;
      cnt_double_q <= cnt_double_d;
    end
  end

  assign bus.o_ready      = s1_adv;
  assign bus.o_valid      = s2_valid_q;
  assign bus.o_data       = s2_data_q;
  assign bus.o_err_single = s2_single_q;
  assign bus.o_err_double = s2_double_q;
  assign bus.o_syndrome   = s2_syn_q;
  assign o_cnt_single     = cnt_single_q;
  assign o_cnt_double     = cnt_double_q;

endmodule

// File: tb/tb_secded_decoder.sv
// Directed bench for secded_decoder: vector table, backpressure stream, counter saturation/clear, mid-stream reset.
module tb_secded_decoder;
  import ecc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic clr_cnt;
  logic [15:0] cnt_s, cnt_d;
  logic [1:0]  cnt_s2, cnt_d2;

  secded_decoder_if bus ();
  secded_decoder_if bus_s ();

  assign bus_s.i_valid = bus.i_valid;
  assign bus_s.i_code  = bus.i_code;
  assign bus_s.i_ready = bus.i_ready;

  secded_decoder #(.CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus), .i_clr_cnt(clr_cnt),
    .o_cnt_single(cnt_s), .o_cnt_double(cnt_d)
  );

  secded_decoder #(.CNT_W(2)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_s), .i_clr_cnt(clr_cnt),
    .o_cnt_single(cnt_s2), .o_cnt_double(cnt_d2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic [3:0] data;
    logic       single;
    logic       dbl;
    logic [2:0] syn;
  } vec_t;

  vec_t tbl [11];
  int checks = 0;
  int errors = 0;
  int exp_cs = 0, exp_cd = 0, exp_cs2 = 0, exp_cd2 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic count_word(input logic single, input logic dbl);
    if (single) begin exp_cs++; if (exp_cs2 < 3) exp_cs2++; end
    if (dbl)    begin exp_cd++; if (exp_cd2 < 3) exp_cd2++; end
  endtask

  task automatic chk_counters(input string nm);
    chk({nm, "_cs"},  cnt_s,  exp_cs);
    chk({nm, "_cd"},  cnt_d,  exp_cd);
    chk({nm, "_cs2"}, cnt_s2, exp_cs2);
    chk({nm, "_cd2"}, cnt_d2, exp_cd2);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    int tx, rx, cyc;
    logic       prev_hold;
    logic [7:0] prev_out;

    tbl[0]  = '{8'h55, 4'hB, 1'b0, 1'b0, 3'd0};
    tbl[1]  = '{8'h45, 4'hB, 1'b1, 1'b0, 3'd5};
    tbl[2]  = '{8'hD5, 4'hB, 1'b1, 1'b0, 3'd0};
    tbl[3]  = '{8'h56, 4'hB, 1'b0, 1'b1, 3'd3};
    tbl[4]  = '{8'h54, 4'hB, 1'b1, 1'b0, 3'd1};
    tbl[5]  = '{8'h15, 4'hB, 1'b1, 1'b0, 3'd7};
    tbl[6]  = '{8'h00, 4'h0, 1'b0, 1'b0, 3'd0};
    tbl[7]  = '{8'hFF, 4'hF, 1'b0, 1'b0, 3'd0};
    tbl[8]  = '{8'hFB, 4'hF, 1'b1, 1'b0, 3'd3};
    tbl[9]  = '{8'hFC, 4'hF, 1'b0, 1'b1, 3'd3};
    tbl[10] = '{8'h30, 4'h6, 1'b0, 1'b1, 3'd3};

    rst_n = 1'b0; clr_cnt = 1'b0;
    bus.i_valid = 1'b0; bus.i_code = 8'h00; bus.i_ready = 1'b1;
    step(); step();
    chk("rst_vld", bus.o_valid, 0);
    chk("rst_data", bus.o_data, 0);
    chk("rst_single", bus.o_err_single, 0);
    chk("rst_double", bus.o_err_double, 0);
    chk("rst_syn", bus.o_syndrome, 0);
    chk_counters("rst");
    rst_n = 1'b1;
    #1;
    chk("rst_ordy", bus.o_ready, 1);
    step();

    // One isolated word per vector: latency, fields, counters.
    for (int k = 0; k < 11; k++) begin
      bus.i_code = tbl[k].code; bus.i_valid = 1'b1;
      step();
      bus.i_valid = 1'b0;
      chk("v_lat1", bus.o_valid, 0);
      step();
      chk("v_vld", bus.o_valid, 1);
      chk("v_data", bus.o_data, tbl[k].data);
      chk("v_single", bus.o_err_single, tbl[k].single);
      chk("v_double", bus.o_err_double, tbl[k].dbl);
      chk("v_syn", bus.o_syndrome, tbl[k].syn);
      step();
      count_word(tbl[k].single, tbl[k].dbl);
      chk("v_gone", bus.o_valid, 0);
      chk_counters("v_cnt");
    end

    // Random backpressure stream of 8 words.
    tx = 0; rx = 0; cyc = 0; prev_hold = 1'b0; prev_out = '0;
    while (rx < 8 && cyc < 300) begin
      bus.i_valid = (tx < 8);
      bus.i_code  = tbl[(tx < 8) ? tx : 0].code;
      bus.i_ready = 1'($urandom_range(0, 1));
      #1;
      if (prev_hold) chk("bp_hold", {bus.o_valid, bus.o_data, bus.o_syndrome}, prev_out);
      chk("bp_ordy", bus.o_ready, ((tx - rx) < 2) || bus.i_ready);
      if (bus.o_valid && bus.i_ready) begin
        chk("bp_data", bus.o_data, tbl[rx].data);
        chk("bp_syn", bus.o_syndrome, tbl[rx].syn);
        count_word(tbl[rx].single, tbl[rx].dbl);
        rx++;
      end
      prev_hold = bus.o_valid & ~bus.i_ready;
      prev_out  = {bus.o_valid, bus.o_data, bus.o_syndrome};
      if (bus.i_valid && bus.o_ready) tx++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp_rx", rx, 8);
    chk("bp_tx", tx, 8);
    bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    step(); step(); step();
    chk("bp_nodup", bus.o_valid, 0);
    chk_counters("bp_cnt");

    // Idle clear, then saturation.
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    exp_cs = 0; exp_cd = 0; exp_cs2 = 0; exp_cd2 = 0;
    chk_counters("clr_idle");
    bus.i_code = 8'h45; bus.i_valid = 1'b1;
    repeat (5) step();
    bus.i_valid = 1'b0;
    repeat (4) step();
    repeat (5) count_word(1'b1, 1'b0);
    chk("sat_cs2", cnt_s2, 3);
    chk_counters("sat");

    // Clear coinciding with an output transfer.
    bus.i_valid = 1'b1;
    step();
    bus.i_valid = 1'b0;
    step();
    chk("clrx_vld", bus.o_valid, 1);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    exp_cs = 0; exp_cd = 0; exp_cs2 = 0; exp_cd2 = 0;
    chk_counters("clrx");

    // Reset with both stages full.
    bus.i_valid = 1'b1;
    repeat (3) step();
    count_word(1'b1, 1'b0);
    chk_counters("pre_rst");
    chk("pre_rst_vld", bus.o_valid, 1);
    rst_n = 1'b0; bus.i_valid = 1'b0;
    step();
    exp_cs = 0; exp_cd = 0; exp_cs2 = 0; exp_cd2 = 0;
    chk("mrst_vld", bus.o_valid, 0);
    chk("mrst_data", bus.o_data, 0);
    chk_counters("mrst");
    rst_n = 1'b1;
    #1;
    chk("mrst_ordy", bus.o_ready, 1);
    step();
    chk("mrst_vld1", bus.o_valid, 0);
    step();
    chk("mrst_vld2", bus.o_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/secded_decoder.md
# secded_decoder

Receive-side decoder for the 8-bit SECDED channel: accepts noisy codewords (Hamming(7,4) plus overall parity), corrects any single-bit error, flags double-bit errors, and emits the 4-bit data nibble with per-word status. It sits after the noise injection stage in the ECC datapath. It is the counterpart of the codeword encoder. It is a two-stage valid/ready pipeline with saturating error-event counters for link-quality monitoring.

## Interface
- `CNT_W`, 16: width of each error-event counter.
- `i_clk` input 1: clock.
- `i_rst_n` input 1: synchronous, active-low reset.
- `i_valid` input 1: `i_code` is valid.
- `o_ready` output 1: decoder can accept a word this cycle.
- `i_code` input 8: received codeword.
- `o_valid` output 1: output word is valid.
- `i_ready` input 1: downstream accepts the output word.
- `o_data` output 4: decoded data nibble, as {d3,d2,d1,d0}.
- `o_err_single` output 1: a single error was corrected in this word.
- `o_err_double` output 1: an uncorrectable double error was found; `o_data` is not trustworthy.
- `o_syndrome` output 3: raw syndrome {s4,s2,s1}, for debug.
- `i_clr_cnt` input 1: synchronously clears both counters.
- `o_cnt_single` output CNT_W: count of accepted words with a corrected single error.
- `o_cnt_double` output CNT_W: count of accepted words with a double error.

## Operation
- Codeword bit map (Hamming position = bit+1):
  - bit0 = p1, bit1 = p2, bit2 = d0, bit3 = p4, bit4 = d1, bit5 = d2, bit6 = d3.
  - bit7 = overall even parity over bits[6:0].
- Syndrome computation:
  - s1 = XOR of bits {0,2,4,6}.
  - s2 = XOR of bits {1,2,5,6}.
  - s4 = XOR of bits {3,4,5,6}.
  - P = XOR of all 8 bits.
- Classification:
  - s=0, P=0: clean word.
  - P=1, s=0: error in bit7. Data is unaffected; flag single.
  - P=1, s≠0: flip bit (s−1), then extract data; flag single.
  - P=0, s≠0: double error. Data is passed uncorrected; flag double. Single is never flagged at the same time.
- Stage 1 registers the codeword, the syndrome and P. Stage 2 registers the corrected data and the flags.
- Counters increment when a word leaves stage 2 (`o_valid & i_ready`).
  - They saturate at all-ones.
  - `i_clr_cnt` takes priority over an increment in the same cycle.
  - When a clear and a transfer coincide, the counter reads 0 on the next cycle.
- `o_syndrome` is reported for every output word, including clean words (value 0).

## Timing
- Reset (`i_rst_n`=0 at a clock edge):
  - Both stage valids are cleared: `o_valid`=0.
  - `o_data`=0, flags=0, `o_syndrome`=0, both counters=0.
  - `o_ready` is 1 in the first cycle after reset is released.
- Reset mid-operation discards any in-flight words; no partial output appears.
- Input transfer occurs on `i_valid & o_ready`. Output transfer occurs on `o_valid & i_ready`.
- Latency is 2 cycles from input transfer to `o_valid`. Throughput is 1 word per cycle when `i_ready` is held at 1.
- Stall rule: `o_ready = ~s1_valid | ~s2_valid | i_ready`.
  - The pipeline advances per stage when the next stage is empty or draining.
  - `o_ready` may depend combinationally on `i_ready`.
- While `o_valid`=1 and `i_ready`=0, all outputs hold stable.
- No word is dropped or duplicated under any `i_valid`/`i_ready` pattern.

## Structure
- Shared package `ecc_pkg` holds:
  - codeword bit-index constants (`P1_BIT`…`PALL_BIT`);
  - syndrome width (3);
  - data width (4).
- The encoder consumes the same package.
- One combinational sub-module, `secded_syndrome` (8-bit code in; syndrome and overall parity out), is instantiated in stage 1. The pipeline, handshake and counters stay in the top module.

## Test plan
- Clean word: `i_code`=8'h55 → 2 cycles later, `o_data`=4'hB, both flags 0, `o_syndrome`=0, counters unchanged.
- Single error in a data bit: 8'h45 (bit4 flipped) → `o_data`=4'hB, `o_err_single`=1, `o_syndrome`=3'd5, `o_cnt_single` increments by 1.
- Single error in the parity bit: 8'hD5 → `o_data`=4'hB, `o_err_single`=1, `o_syndrome`=0.
- Double error: 8'h56 (bits 0 and 1 flipped) → `o_err_double`=1, `o_err_single`=0, `o_syndrome`=3'd3, `o_cnt_double` increments by 1.
- Backpressure: stream 8 words with `i_ready` toggling at random → outputs arrive in order with no loss or duplicates; `o_ready` is 0 only while both stages are full and `i_ready`=0.
- Counter saturation and clear:
  - With `CNT_W`=2, send 5 single-error words → `o_cnt_single`=3.
  - Assert `i_clr_cnt` in the same cycle as a transfer → count reads 0.
  - Assert `i_rst_n`=0 mid-stream → `o_valid`=0 and counters=0 on the next cycle.
